// File: rtl/paddle_ctrl_if.sv
// Strobe inputs and paddle status bundle between the debouncer/game side and paddle_ctrl.
interface paddle_ctrl_if #(
  parameter int unsigned Y_W    = 10,
  parameter int unsigned PEND_W = 3
);
  logic                     up_v;
  logic                     down_v;
  logic                     frame_tick;
  logic [Y_W-1:0]           y_pos;
  logic signed [PEND_W-1:0] pending;
  logic                     moving;
  logic                     at_top;
  logic                     at_bottom;
  logic                     dropped;

  modport master (
    output up_v, down_v, frame_tick,
    input  y_pos, pending, moving, at_top, at_bottom, dropped
  );

  modport slave (
    input  up_v, down_v, frame_tick,
    output y_pos, pending, moving, at_top, at_bottom, dropped
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Paddle vertical position controller: queues debounced up/down presses in a
// saturating signed counter and applies one clamped STEP move per frame tick.
module paddle_ctrl #(
  parameter int unsigned Y_W    = 10,
  parameter int unsigned Y_MIN  = 0,
  parameter int unsigned Y_MAX  = 400,
  parameter int unsigned Y_INIT = 200,
  parameter int unsigned STEP   = 4,
  parameter int unsigned PEND_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  paddle_ctrl_if.slave bus
);

  localparam int unsigned EW = Y_W + 1;
  localparam int unsigned SW = PEND_W + 1;
  localparam logic signed [SW-1:0] P_MAX = SW'(2**(PEND_W-1) - 1);
  localparam logic signed [SW-1:0] P_MIN = -P_MAX;

  logic [EW-1:0]        y_ext;
  logic [EW-1:0]        room_up;
  logic [EW-1:0]        room_dn;
  logic [Y_W-1:0]       y_nxt;
  logic signed [SW-1:0] p_ext;
  logic signed [SW-1:0] base;
  logic signed [SW-1:0] delta;
  logic signed [SW-1:0] sum;
  logic [PEND_W-1:0]    pend_nxt;
  logic                 drop_c;

  // Next-state: consume one queued move on a tick, then add this cycle's strobe.
  always_comb begin
    y_ext    = {1'b0, bus.y_pos};
    room_up  = y_ext - EW'(Y_MIN);
    room_dn  = EW'(Y_MAX) - y_ext;
    p_ext    = {bus.pending[PEND_W-1], bus.pending};
    y_nxt    = bus.y_pos;
    base     = p_ext;
    delta    = '0;
    drop_c   = 1'b0;

    if (bus.frame_tick) begin
      if (p_ext > 0) begin
        if (room_up < EW'(STEP)) begin
          y_nxt = Y_W'(Y_MIN);
          base  = '0;
        end else begin
          y_nxt = Y_W'(y_ext - EW'(STEP));
          base  = p_ext - SW'(1);
        end
      end else if (p_ext < 0) begin
        if (room_dn < EW'(STEP)) begin
          y_nxt = Y_W'(Y_MAX);
          base  = '0;
        end else begin
          y_nxt = Y_W'(y_ext + EW'(STEP));
          base  = p_ext + SW'(1);
        end
      end
    end

    case ({bus.up_v, bus.down_v})
      2'b10:   delta = SW'(1);
      2'b01:   delta = '1;
      default: delta = '0;
    endcase

    sum = base + delta;
    if (sum > P_MAX) begin
      pend_nxt = P_MAX[PEND_W-1:0];
      drop_c   = 1'b1;
    end else if (sum < P_MIN) begin
      pend_nxt = P_MIN[PEND_W-1:0];
      drop_c   = 1'b1;
    end else begin
      pend_nxt = sum[PEND_W-1:0];
    end
  end

  // Status flags come from next-state values so they line up with y_pos/pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.y_pos     <= Y_W'(Y_INIT);
      bus.pending   <= '0;
      bus.moving    <= 1'b0;
      bus.at_top    <= (Y_INIT == Y_MIN);
      bus.at_bottom <= (Y_INIT == Y_MAX);
      bus.dropped   <= 1'b0;
    end else begin
      bus.y_pos     <= y_nxt;
      bus.pending   <= pend_nxt;
      bus.moving    <= (pend_nxt != '0);
      bus.at_top    <= (y_nxt == Y_W'(Y_MIN));
      bus.at_bottom <= (y_nxt == Y_W'(Y_MAX));
      bus.dropped   <= bus.dropped | drop_c;
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: two instances (Y_INIT=200 and Y_INIT=6) run against an
// integer reference model, with directed scenarios followed by random traffic.
module tb_paddle_ctrl;

  localparam int Y_MIN = 0;
  localparam int Y_MAX = 400;
  localparam int STEP  = 4;
  localparam int P_LIM = 3;

  logic clk;
  logic rst_n;

  paddle_ctrl_if #(.Y_W(10), .PEND_W(3)) b0 ();
  paddle_ctrl_if #(.Y_W(10), .PEND_W(3)) b1 ();

  paddle_ctrl #(.Y_W(10), .Y_MIN(0), .Y_MAX(400), .Y_INIT(200), .STEP(4), .PEND_W(3))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  paddle_ctrl #(.Y_W(10), .Y_MIN(0), .Y_MAX(400), .Y_INIT(6), .STEP(4), .PEND_W(3))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fails;
  int m_y[2];
  int m_p[2];
  int m_drop[2];
  int m_init[2];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: one clock edge of the paddle rules, in plain integer arithmetic.
  task automatic model_edge(input int k, input bit rst, input bit u, input bit d, input bit t);
    int dd;
    int base;
    int s;
    if (!rst) begin
      m_y[k] = m_init[k]; m_p[k] = 0; m_drop[k] = 0;
      return;
    end
    dd   = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
    base = m_p[k];
    if (t && m_p[k] > 0) begin
      if (m_y[k] - Y_MIN < STEP) begin m_y[k] = Y_MIN; base = 0; end
      else begin m_y[k] = m_y[k] - STEP; base = m_p[k] - 1; end
    end else if (t && m_p[k] < 0) begin
      if (Y_MAX - m_y[k] < STEP) begin m_y[k] = Y_MAX; base = 0; end
      else begin m_y[k] = m_y[k] + STEP; base = m_p[k] + 1; end
    end
    s = base + dd;
    if (s > P_LIM)  begin s = P_LIM;  m_drop[k] = 1; end
    if (s < -P_LIM) begin s = -P_LIM; m_drop[k] = 1; end
    m_p[k] = s;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".y0"},    int'(b0.y_pos),           m_y[0]);
    check_val({tag, ".p0"},    int'($signed(b0.pending)), m_p[0]);
    check_val({tag, ".mv0"},   int'(b0.moving),          int'(m_p[0] != 0));
    check_val({tag, ".top0"},  int'(b0.at_top),          int'(m_y[0] == Y_MIN));
    check_val({tag, ".bot0"},  int'(b0.at_bottom),       int'(m_y[0] == Y_MAX));
    check_val({tag, ".drop0"}, int'(b0.dropped),         m_drop[0]);
    check_val({tag, ".y1"},    int'(b1.y_pos),           m_y[1]);
    check_val({tag, ".p1"},    int'($signed(b1.pending)), m_p[1]);
    check_val({tag, ".mv1"},   int'(b1.moving),          int'(m_p[1] != 0));
    check_val({tag, ".top1"},  int'(b1.at_top),          int'(m_y[1] == Y_MIN));
    check_val({tag, ".bot1"},  int'(b1.at_bottom),       int'(m_y[1] == Y_MAX));
    check_val({tag, ".drop1"}, int'(b1.dropped),         m_drop[1]);
  endtask

  // Drive both instances for one cycle, advance the model, check #1 after the edge.
  task automatic step(input string tag, input bit rst,
                      input bit u0, input bit d0, input bit t0,
                      input bit u1, input bit d1, input bit t1);
    rst_n = rst;
    b0.up_v = u0; b0.down_v = d0; b0.frame_tick = t0;
    b1.up_v = u1; b1.down_v = d1; b1.frame_tick = t1;
    @(posedge clk);
    model_edge(0, rst, u0, d0, t0);
    model_edge(1, rst, u1, d1, t1);
    #1;
    check_all(tag);
  endtask

  task automatic s0(input string tag, input bit u, input bit d, input bit t);
    step(tag, 1'b1, u, d, t, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic s1(input string tag, input bit u, input bit d, input bit t);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b0, u, d, t);
  endtask

  task automatic do_reset();
    step("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int dir;
    n_checks = 0;
    n_fails  = 0;
    m_init[0] = 200;
    m_init[1] = 6;
    m_y[0] = 0; m_p[0] = 0; m_drop[0] = 0;
    m_y[1] = 0; m_p[1] = 0; m_drop[1] = 0;
    rst_n = 1'b0;
    b0.up_v = 1'b0; b0.down_v = 1'b0; b0.frame_tick = 1'b0;
    b1.up_v = 1'b0; b1.down_v = 1'b0; b1.frame_tick = 1'b0;

    // Reset state
    do_reset();
    check_val("reset_y", int'(b0.y_pos), 200);
    check_val("reset_top1", int'(b1.at_top), 0);

    // Two ups, two ticks
    s0("up", 1, 0, 0);
    check_val("tp2_p1", int'($signed(b0.pending)), 1);
    s0("up", 1, 0, 0);
    s0("tick", 0, 0, 1);
    check_val("tp2_y196", int'(b0.y_pos), 196);
    s0("tick", 0, 0, 1);
    check_val("tp2_y192", int'(b0.y_pos), 192);
    check_val("tp2_mv", int'(b0.moving), 0);

    // Saturation and dropped
    do_reset();
    repeat (5) s0("sat_up", 1, 0, 0);
    check_val("tp3_sat", int'($signed(b0.pending)), 3);
    check_val("tp3_drop", int'(b0.dropped), 1);
    repeat (3) s0("sat_tick", 0, 0, 1);
    check_val("tp3_y188", int'(b0.y_pos), 188);
    check_val("tp3_drop_sticky", int'(b0.dropped), 1);

    // Cancelling strobes, strobe coinciding with tick
    do_reset();
    s0("both", 1, 1, 0);
    check_val("tp4_both_p", int'($signed(b0.pending)), 0);
    check_val("tp4_both_drop", int'(b0.dropped), 0);
    s0("up", 1, 0, 0);
    s0("up_tick", 1, 0, 1);
    check_val("tp4_y196", int'(b0.y_pos), 196);
    check_val("tp4_p1", int'($signed(b0.pending)), 1);

    // Top clamp on the Y_INIT=6 instance
    repeat (3) s1("top_up", 1, 0, 0);
    s1("top_tick", 0, 0, 1);
    check_val("tp5_y2", int'(b1.y_pos), 2);
    check_val("tp5_p2", int'($signed(b1.pending)), 2);
    s1("top_tick", 0, 0, 1);
    check_val("tp5_y0", int'(b1.y_pos), 0);
    check_val("tp5_p0", int'($signed(b1.pending)), 0);
    check_val("tp5_top", int'(b1.at_top), 1);
    s1("top_up", 1, 0, 0);
    s1("top_tick", 0, 0, 1);
    check_val("tp5_stay", int'(b1.y_pos), 0);
    check_val("tp5_clear", int'($signed(b1.pending)), 0);

    // Reset mid-operation
    do_reset();
    s0("dn", 0, 1, 0);
    s0("dn", 0, 1, 0);
    s0("tick", 0, 0, 1);
    s0("tick", 0, 0, 1);
    s0("dn", 0, 1, 0);
    s0("dn", 0, 1, 0);
    check_val("tp6_y208", int'(b0.y_pos), 208);
    check_val("tp6_pm2", int'($signed(b0.pending)), -2);
    step("rst_mid", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("tp6_y200", int'(b0.y_pos), 200);
    check_val("tp6_p0", int'($signed(b0.pending)), 0);
    check_val("tp6_drop0", int'(b0.dropped), 0);

    // Random traffic with a directional bias per block so both edges get hit
    dir = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, u0, d0, u1, d1;
      if (i % 250 == 0) dir = int'($urandom_range(0, 2));
      r  = ($urandom_range(0, 399) != 0);
      u0 = ($urandom_range(0, 9) < ((dir == 0) ? 6 : 2));
      d0 = ($urandom_range(0, 9) < ((dir == 1) ? 6 : 2));
      u1 = ($urandom_range(0, 9) < ((dir == 1) ? 6 : 2));
      d1 = ($urandom_range(0, 9) < ((dir == 0) ? 6 : 2));
      step("rand", r, u0, d0, ($urandom_range(0, 3) == 0),
           u1, d1, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Consumes the single-cycle button strobes from the button debouncer, one strobe per press.
- Queues up/down move requests in a saturating signed pending counter.
- Applies one STEP-pixel move per frame tick to a clamped paddle vertical position.
- Its outputs feed the VGA drawing logic and game logic.

Parameters:
- Y_W, 10, width of position bus.
- Y_MIN, 0, topmost legal y_pos.
- Y_MAX, 400, bottommost legal y_pos.
- Y_INIT, 200, y_pos after reset. Must satisfy Y_MIN <= Y_INIT <= Y_MAX.
- STEP, 4, pixels moved per applied request. Must satisfy 1 <= STEP <= Y_MAX-Y_MIN.
- PEND_W, 3, pending counter width in two's complement. Range is ±(2^(PEND_W-1)-1), i.e. -3..+3 at the default.

Ports:
- clk  input  1  system clock. All logic is on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- up_v  input  1  one-cycle strobe, one per debounced "up" press.
- down_v  input  1  one-cycle strobe, one per debounced "down" press.
- frame_tick  input  1  one-cycle strobe, once per video frame.
- y_pos  output  Y_W  current paddle top-edge y, registered.
- pending  output  PEND_W  signed queued moves, registered. Positive means up (y decreasing).
- moving  output  1  registered; 1 iff the next-state pending is nonzero.
- at_top  output  1  registered; 1 iff y_pos == Y_MIN.
- at_bottom  output  1  registered; 1 iff y_pos == Y_MAX.
- dropped  output  1  sticky; set when a strobe is lost to saturation.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: on any edge with rst_n=0, all other inputs are ignored and the outputs take their reset values.
- Reset values:
  - y_pos=Y_INIT, pending=0, moving=0, dropped=0.
  - at_top=(Y_INIT==Y_MIN), at_bottom=(Y_INIT==Y_MAX).
- Per-cycle strobe delta d:
  - +1 if up_v only, -1 if down_v only.
  - 0 if both or neither. Simultaneous up_v and down_v cancel and never set dropped.
- Consume step c, evaluated only when frame_tick=1, using the registered pending p:
  - p>0: if y_pos-Y_MIN < STEP, then y_pos<=Y_MIN and base<=0 (clamp discards the remaining up requests). Otherwise y_pos<=y_pos-STEP and base<=p-1.
  - p<0: if Y_MAX-y_pos < STEP, then y_pos<=Y_MAX and base<=0. Otherwise y_pos<=y_pos+STEP and base<=p+1.
  - p==0: y_pos unchanged, base=p.
- Without frame_tick: base=p.
- A request in the direction of an edge already reached still queues. At the next tick it consumes with the clamp rule and is cleared with no movement.
- Next pending = sat(base+d), where sat clamps to ±(2^(PEND_W-1)-1).
- If the clamp actually discards a nonzero d, dropped<=1. dropped stays 1 until reset.
- A strobe and a frame_tick on the same cycle: the tick consumes the pre-edge p, and the strobe is added after.
- Latency:
  - A strobe at edge n is visible on pending at n+1.
  - The position changes on the edge where frame_tick=1 and p≠0, and is visible the following cycle.
  - At most one STEP is applied per frame_tick.
- at_top, at_bottom and moving are computed from the next-state values so they stay aligned with y_pos and pending (no extra cycle lag).
- Arithmetic: comparisons are done unsigned in Y_W+1 bits so that y_pos-STEP never wraps below zero.
- No handshake back to the debouncer; the strobes are fire-and-forget.

Test Plan:
1. Reset with defaults, rst_n held low 2 cycles -> y_pos=200, pending=0, moving=0, at_top=0, at_bottom=0, dropped=0.
2. Two up_v strobes, then two frame_ticks -> pending 1→2, then y_pos 196 with pending=1, then y_pos 192 with pending=0 and moving=0.
3. Five up_v strobes, no tick -> pending saturates at 3 and dropped=1. Then three ticks -> y_pos=188, pending=0, dropped still 1.
4. Edge cases for strobes:
   - up_v=down_v=1 in the same cycle -> pending unchanged at 0, dropped=0.
   - Separately, with pending=1, up_v and frame_tick in the same cycle -> y_pos=196, pending stays 1.
5. Top clamp, Y_INIT=6, three up_v strobes:
   - First tick -> y_pos=2, pending=2.
   - Second tick -> y_pos=0, pending=0, at_top=1.
   - Further up_v then tick -> y_pos stays 0, pending returns to 0.
6. Reset mid-operation: pending=-2, y_pos=208, then rst_n=0 coinciding with frame_tick and down_v -> y_pos=200, pending=0, dropped=0 on the next cycle.
